// File: rtl/game_pkg.sv
// Shared definitions for the ball-and-paddle match logic: mode encoding,
// match FSM state type, score width and a saturating score increment.
package game_pkg;

    localparam int SCORE_W = 5;

    localparam logic [1:0] MODE_TENNIS   = 2'b00;
    localparam logic [1:0] MODE_SOCCER   = 2'b01;
    localparam logic [1:0] MODE_SQUASH   = 2'b10;
    localparam logic [1:0] MODE_PRACTICE = 2'b11;

    typedef enum logic [1:0] {
        ST_SERVE_WAIT = 2'd0,
        ST_RALLY      = 2'd1,
        ST_PAUSE      = 2'd2,
        ST_OVER       = 2'd3
    } match_state_t;

    // Scores stop at all-ones rather than wrapping back to zero.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == {SCORE_W{1'b1}}) ? s : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector: rise pulses for one cycle, one edge after
// the input is first sampled high.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q  <= 1'b0;
            rise <= 1'b0;
        end else begin
            d_q  <= d;
            rise <= d & ~d_q;
        end
    end

endmodule

// File: rtl/match_sequencer.sv
// Match-level sequencer: serve / rally / pause / game-over flow and scoring.
// Define MATCH_SEQ_DEUCE_EN to require a two-point lead to win.
//
// state         | meaning
// ST_SERVE_WAIT | ball held at serve position, waiting for serve or auto delay
// ST_RALLY      | ball in play, waiting for a wall miss
// ST_PAUSE      | ball frozen for PAUSE_CYCLES after a point
// ST_OVER       | match finished, winner held until a serve rise restarts
module match_sequencer
    import game_pkg::*;
#(
    parameter int WIN_SCORE    = 15,
    parameter int SERVE_DELAY  = 25_000_000,
    parameter int PAUSE_CYCLES = 12_500_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               serve_type,
    input  logic               serve,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               ball_en,
    output logic               ball_load,
    output logic               launch,
    output logic               serve_side,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               game_over,
    output logic               winner
);

    localparam int CNT_MAX = (SERVE_DELAY > PAUSE_CYCLES) ? SERVE_DELAY : PAUSE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]   SERVE_TC = CNT_W'(SERVE_DELAY - 1);
    localparam logic [CNT_W-1:0]   PAUSE_TC = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN_S    = SCORE_W'(WIN_SCORE);

    match_state_t       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic [SCORE_W-1:0] p1_n, p2_n;
    logic               side_q, side_d;
    logic               launch_q, launch_d;
    logic               winner_q, winner_d;
    logic               serve_rise;
    logic               p1_win, p2_win;

    edge_detect u_serve_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (serve),
        .rise (serve_rise)
    );

`ifdef MATCH_SEQ_DEUCE_EN
    logic [SCORE_W:0] p1_x, p2_x;

    assign p1_x = {1'b0, p1_q};
    assign p2_x = {1'b0, p2_q};

    // Once both players have reached 30 a lead of two is unreachable before
    // saturation, so a one-point lead at that stage ends the match.
    assign p1_win = (p1_q >= WIN_S) &&
                    ((p1_x >= p2_x + (SCORE_W+1)'(2)) ||
                     ((p1_q > p2_q) && (p2_q >= SCORE_W'(30))));
    assign p2_win = (p2_q >= WIN_S) &&
                    ((p2_x >= p1_x + (SCORE_W+1)'(2)) ||
                     ((p2_q > p1_q) && (p1_q >= SCORE_W'(30))));
`else
    assign p1_win = (p1_q >= WIN_S);
    assign p2_win = (p2_q >= WIN_S);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_SERVE_WAIT;
            cnt_q    <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
            side_q   <= 1'b0;
            launch_q <= 1'b0;
            winner_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            side_q   <= side_d;
            launch_q <= launch_d;
            winner_q <= winner_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        side_d   = side_q;
        launch_d = 1'b0;
        winner_d = winner_q;
        p1_n     = p1_q;
        p2_n     = p2_q;

        case (state_q)
            ST_SERVE_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if ((serve_type && serve_rise) || (!serve_type && (cnt_q == SERVE_TC))) begin
                    state_d  = ST_RALLY;
                    launch_d = 1'b1;
                    cnt_d    = '0;
                end
            end

            ST_RALLY: begin
                if (miss_left || miss_right) begin
                    // miss_left has priority: P2 takes the point on a double miss
                    if (miss_left) begin
                        p2_n = sat_inc(p2_q);
                    end else begin
                        p1_n = sat_inc(p1_q);
                    end
                    p1_d = p1_n;
                    p2_d = p2_n;

                    case (mode)
                        MODE_TENNIS: side_d = p1_n[1] ^ p2_n[1] ^ (p1_n[0] & p2_n[0]);
                        MODE_SOCCER: side_d = ~miss_left;
                        MODE_SQUASH: side_d = miss_left;
                        default:     side_d = 1'b0;
                    endcase

                    state_d = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                if (cnt_q == PAUSE_TC) begin
                    cnt_d = '0;
                    if ((mode != MODE_PRACTICE) && (p1_win || p2_win)) begin
                        state_d  = ST_OVER;
                        winner_d = p2_win;
                    end else begin
                        state_d = ST_SERVE_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_OVER: begin
                if (serve_rise) begin
                    p1_d    = '0;
                    p2_d    = '0;
                    side_d  = 1'b0;
                    state_d = ST_SERVE_WAIT;
                end
            end

            default: state_d = ST_SERVE_WAIT;
        endcase
    end

    assign ball_en    = (state_q == ST_RALLY);
    assign ball_load  = (state_q == ST_SERVE_WAIT);
    assign game_over  = (state_q == ST_OVER);
    assign launch     = launch_q;
    assign serve_side = side_q;
    assign p1_score   = p1_q;
    assign p2_score   = p2_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed self-checking bench for match_sequencer (SERVE_DELAY=4,
// PAUSE_CYCLES=3, WIN_SCORE=3).
module tb_match_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       serve_type;
    logic       serve;
    logic       miss_left;
    logic       miss_right;
    logic       ball_en;
    logic       ball_load;
    logic       launch;
    logic       serve_side;
    logic [4:0] p1_score;
    logic [4:0] p2_score;
    logic       game_over;
    logic       winner;

    int checks = 0;
    int errors = 0;

    match_sequencer #(
        .WIN_SCORE    (3),
        .SERVE_DELAY  (4),
        .PAUSE_CYCLES (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .serve_type (serve_type),
        .serve      (serve),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .ball_en    (ball_en),
        .ball_load  (ball_load),
        .launch     (launch),
        .serve_side (serve_side),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic point(input logic ml, input logic mr);
        miss_left  = ml;
        miss_right = mr;
        tick();
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    task automatic pause3();
        repeat (3) tick();
    endtask

    task automatic wait_rally(input string tag);
        int n = 0;
        while (!ball_en && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_en"}, ball_en, 1);
        chk({tag, "_launch"}, launch, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mode = 2'b00; serve_type = 1'b0; serve = 1'b0;
        miss_left = 1'b0; miss_right = 1'b0;
        tick(); tick();
        chk("rst_load", ball_load, 1);
        chk("rst_en", ball_en, 0);
        chk("rst_launch", launch, 0);
        chk("rst_over", game_over, 0);
        chk("rst_winner", winner, 0);
        chk("rst_p1", p1_score, 0);
        chk("rst_p2", p2_score, 0);
        chk("rst_side", serve_side, 0);

        // auto serve, with a stray miss in SERVE_WAIT that must be ignored
        rst = 1'b0;
        point(1'b0, 1'b1);
        chk("miss_ignored", p1_score, 0);
        chk("auto_load1", ball_load, 1);
        tick(); tick();
        chk("auto_load3", ball_load, 1);
        chk("auto_en3", ball_en, 0);
        tick();
        chk("auto_en4", ball_en, 1);
        chk("auto_launch4", launch, 1);
        chk("auto_load4", ball_load, 0);
        tick();
        chk("auto_launch5", launch, 0);

        // soccer: P2 scores, conceding P1 serves
        mode = 2'b01;
        point(1'b1, 1'b0);
        chk("soc_p2", p2_score, 1);
        chk("soc_p1", p1_score, 0);
        chk("soc_side", serve_side, 0);
        chk("soc_en", ball_en, 0);
        chk("soc_load", ball_load, 0);
        tick(); tick();
        chk("soc_pause_load", ball_load, 0);
        tick();
        chk("soc_back_load", ball_load, 1);
        wait_rally("rally2");

        // squash, both misses together: P2 takes it and serves
        mode = 2'b10;
        point(1'b1, 1'b1);
        chk("sim_p2", p2_score, 2);
        chk("sim_p1", p1_score, 0);
        chk("sim_side", serve_side, 1);
        pause3();
        chk("sim_over", game_over, 0);
        chk("sim_load", ball_load, 1);
        wait_rally("rally3");

        // tennis: 1-2 -> sum 3 -> side 1
        mode = 2'b00;
        point(1'b0, 1'b1);
        chk("ten_p1", p1_score, 1);
        chk("ten_side", serve_side, 1);
        pause3();
        wait_rally("rally4");

        // async reset between edges while in RALLY
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_p1", p1_score, 0);
        chk("arst_p2", p2_score, 0);
        chk("arst_en", ball_en, 0);
        chk("arst_load", ball_load, 1);
        chk("arst_side", serve_side, 0);
        tick();
        rst = 1'b0;

        // manual serve
        serve_type = 1'b1;
        repeat (20) begin
            tick();
            chk("man_hold", ball_en, 0);
        end
        serve = 1'b1;
        tick();
        chk("man_n", ball_en, 0);
        tick();
        chk("man_n1_en", ball_en, 1);
        chk("man_n1_launch", launch, 1);
        tick();
        chk("man_launch_clr", launch, 0);
        point(1'b0, 1'b1);
        pause3();
        repeat (8) tick();
        chk("man_no_relaunch", ball_en, 0);
        chk("man_no_relaunch_load", ball_load, 1);
        serve = 1'b0;
        tick();
        serve = 1'b1;
        tick();
        chk("man_rise2_n", ball_en, 0);
        tick();
        chk("man_rise2_en", ball_en, 1);
        chk("man_rise2_launch", launch, 1);
        serve = 1'b0;

        // win in tennis, P1
        serve_type = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifndef MATCH_SEQ_DEUCE_EN
        wait_rally("win_r1");
        point(1'b0, 1'b1);
        chk("win_p1_1", p1_score, 1);
        chk("win_side_1", serve_side, 0);
        pause3();
        wait_rally("win_r2");
        point(1'b0, 1'b1);
        chk("win_p1_2", p1_score, 2);
        chk("win_side_2", serve_side, 1);
        pause3();
        chk("win_not_over", game_over, 0);
        wait_rally("win_r3");
        point(1'b0, 1'b1);
        chk("win_p1_3", p1_score, 3);
        tick(); tick();
        chk("win_pause_over", game_over, 0);
        tick();
`else
        for (int i = 0; i < 4; i++) begin
            wait_rally("deuce_r");
            point(i >= 2, i < 2);
            pause3();
        end
        chk("deuce_p1_22", p1_score, 2);
        chk("deuce_p2_22", p2_score, 2);
        wait_rally("deuce_r5");
        point(1'b0, 1'b1);
        pause3();
        chk("deuce_32_over", game_over, 0);
        chk("deuce_32_load", ball_load, 1);
        wait_rally("deuce_r6");
        point(1'b0, 1'b1);
        chk("deuce_p1_4", p1_score, 4);
        pause3();
`endif
        chk("win_over", game_over, 1);
        chk("win_winner", winner, 0);
        chk("win_en", ball_en, 0);
        chk("win_load", ball_load, 0);
        repeat (6) tick();
        chk("over_hold", game_over, 1);

        // restart from OVER with auto serve selected
        serve = 1'b1;
        tick();
        chk("restart_n", game_over, 1);
        tick();
        chk("restart_over", game_over, 0);
        chk("restart_p1", p1_score, 0);
        chk("restart_p2", p2_score, 0);
        chk("restart_load", ball_load, 1);
        chk("restart_side", serve_side, 0);
        serve = 1'b0;

        // squash, P2 wins 3-0
        mode = 2'b10;
        for (int i = 0; i < 3; i++) begin
            wait_rally("p2w_r");
            point(1'b1, 1'b0);
            pause3();
        end
        chk("p2w_over", game_over, 1);
        chk("p2w_winner", winner, 1);
        chk("p2w_side", serve_side, 1);
        serve = 1'b1;
        tick(); tick();
        chk("p2w_restart", game_over, 0);
        serve = 1'b0;

        // practice: never ends, scores saturate at 31, P1 always serves
        mode = 2'b11;
        for (int i = 0; i < 33; i++) begin
            wait_rally("prac_r");
            point(1'b1, 1'b0);
            pause3();
        end
        chk("prac_p2_sat", p2_score, 31);
        chk("prac_p1", p1_score, 0);
        chk("prac_over", game_over, 0);
        chk("prac_side", serve_side, 0);
        chk("prac_load", ball_load, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
